// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time into a word-wide RAM; sub-word stores are read-modify-write.
// Latency accept->resp_valid: load 3, word store 2, sub-word store 4; req_ready low from accept until DONE exits.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        ram_read,
  output logic        ram_write,
  output logic        ram_word,
  output logic        ram_sign,
  output logic [31:0] ram_address,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Extension works on the word arriving in CAP so the result is ready on entry to DONE.
  always_comb begin
    load_ext = ram_dataOut;
    case (size_q)
      2'd0:    load_ext = {{24{sgn_q & ram_dataOut[7]}}, ram_dataOut[7:0]};
      2'd1:    load_ext = {{16{sgn_q & ram_dataOut[15]}}, ram_dataOut[15:0]};
      default: load_ext = ram_dataOut;
    endcase
  end

  always_comb begin
    merged = wdata_q;
    case (size_q)
      2'd0:    merged = {old_q[31:8], wdata_q[7:0]};
      2'd1:    merged = {old_q[31:16], wdata_q[15:0]};
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          // size 3 is treated as a word, so size[1] alone marks a full-word access
          state_d = (req_write && req_size[1]) ? WR : RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        old_d = ram_dataOut;
        if (write_q) begin
          state_d = WR;
        end else begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      WR: begin
        rdata_d = 32'd0;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    resp_valid  = (state_q == DONE);
    resp_rdata  = rdata_q;
    ram_read    = (state_q == RD);
    ram_write   = (state_q == WR);
    ram_word    = 1'b1;
    ram_sign    = 1'b0;
    ram_address = (state_q == RD || state_q == CAP || state_q == WR) ? addr_q : 32'd0;
    ram_dataIn  = (state_q == WR) ? merged : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      old_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array RAM, transaction-level reference model with a per-cycle
// compare process, directed literal checks and a randomized phase including a mid-stream reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        ram_read, ram_write, ram_word, ram_sign;
  logic [31:0] ram_address, ram_dataIn;
  logic [31:0] ram_dataOut = 32'd0;

  int tests = 0;
  int fails = 0;

  logic [7:0] ram  [0:1023];
  logic [7:0] gmem [0:1023];

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_word(ram_word), .ram_sign(ram_sign),
    .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  always #5 clk = ~clk;

  // RAM: full-word little-endian access at any byte address, read data registered.
  int ra;
  always @(posedge clk) begin
    ra = int'(ram_address[9:0]);
    if (ram_read) ram_dataOut <= {ram[ra+3], ram[ra+2], ram[ra+1], ram[ra]};
    if (ram_write) begin
      ram[ra]   <= ram_dataIn[7:0];
      ram[ra+1] <= ram_dataIn[15:8];
      ram[ra+2] <= ram_dataIn[23:16];
      ram[ra+3] <= ram_dataIn[31:24];
    end
  end

  task automatic chk1(input string nm, input logic act, input logic want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, want, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [31:0] gword(input int a);
    return {gmem[a+3], gmem[a+2], gmem[a+1], gmem[a]};
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] old, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz >= 2'd2) return old;
    if (sz == 2'd0) begin
      v = old % 256;
      if (sg && v >= 128) v = v - 32'd256;
    end else begin
      v = old % 65536;
      if (sg && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // Reference model: k counts cycles since the accept edge; each kind of request has a fixed
  // total latency and fixed cycles at which the RAM is read or written.
  bit          busy = 1'b0;
  int          k = 0, lat_m = 0, rd_at = 0, wr_at = 0, ma = 0;
  logic [31:0] exp_addr = 0, exp_wdat = 0, exp_rdata = 0, last_rdata = 0, mold = 0;
  bit          is_word;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy = 1'b0;
      k = 0;
      last_rdata = 32'd0;
    end else if (busy) begin
      if (k == wr_at) begin
        ma = int'(exp_addr[9:0]);
        gmem[ma]   = exp_wdat[7:0];
        gmem[ma+1] = exp_wdat[15:8];
        gmem[ma+2] = exp_wdat[23:16];
        gmem[ma+3] = exp_wdat[31:24];
      end
      if (k == lat_m) busy = 1'b0;
      else begin
        k++;
        if (k == lat_m) last_rdata = exp_rdata;
      end
    end else if (req_valid) begin
      mold     = gword(int'(req_addr[9:0]));
      is_word  = (req_size >= 2'd2);
      busy     = 1'b1;
      k        = 1;
      exp_addr = req_addr;
      if (!req_write) begin
        lat_m = 3; rd_at = 1; wr_at = 0;
        exp_rdata = load_val(mold, req_size, req_signed);
      end else begin
        exp_rdata = 32'd0;
        if (is_word) exp_wdat = req_wdata;
        else if (req_size == 2'd0) exp_wdat = (mold & ~32'hFF) | (req_wdata & 32'hFF);
        else exp_wdat = (mold & ~32'hFFFF) | (req_wdata & 32'hFFFF);
        lat_m = is_word ? 2 : 4;
        rd_at = is_word ? 0 : 1;
        wr_at = is_word ? 1 : 3;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk32("rst_resp_rdata", resp_rdata, 32'd0);
      chk1("rst_ram_read", ram_read, 1'b0);
      chk1("rst_ram_write", ram_write, 1'b0);
      chk32("rst_ram_address", ram_address, 32'd0);
      chk32("rst_ram_dataIn", ram_dataIn, 32'd0);
    end else begin
      chk1("req_ready", req_ready, !busy);
      chk1("resp_valid", resp_valid, busy && k == lat_m);
      chk32("resp_rdata", resp_rdata, last_rdata);
      chk1("ram_read", ram_read, busy && k == rd_at);
      chk1("ram_write", ram_write, busy && k == wr_at);
      chk1("ram_word", ram_word, 1'b1);
      chk1("ram_sign", ram_sign, 1'b0);
      if (busy && k < lat_m) chk32("ram_address", ram_address, exp_addr);
      if (busy && k == wr_at) chk32("ram_dataIn", ram_dataIn, exp_wdat);
    end
  end

  int n_rd = 0, n_wr = 0, n_rv = 0;
  logic [31:0] last_wdat = 32'd0;
  always @(negedge clk) begin
    if (ram_read) n_rd++;
    if (ram_write) begin
      n_wr++;
      last_wdat = ram_dataIn;
    end
    if (resp_valid) n_rv++;
  end

  // Called just after a rising edge; returns cycles from accept to resp_valid and the response data.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd);
    int guard;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 20);
    chk1("accept_timeout", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    rd = resp_rdata;
    @(posedge clk);
    #1;
  endtask

  int          lat, w0, r0, v0, bad;
  logic [31:0] rd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]  = 8'($urandom);
      gmem[i] = ram[i];
    end
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk1("ready_after_reset", req_ready, 1'b1);

    w0 = n_wr;
    do_req(1'b1, 2'd2, 1'b0, 32'd200, 32'hF00FF176, lat, rd);
    chk32("st_word_lat", 32'(lat), 32'd2);
    chk32("st_word_nwr", 32'(n_wr - w0), 32'd1);
    chk32("st_word_din", last_wdat, 32'hF00FF176);
    chk32("st_word_rdata", rd, 32'd0);

    do_req(1'b0, 2'd2, 1'b0, 32'd200, 32'd0, lat, rd);
    chk32("ld_word_lat", 32'(lat), 32'd3);
    chk32("ld_word", rd, 32'hF00FF176);
    do_req(1'b0, 2'd1, 1'b1, 32'd200, 32'd0, lat, rd);
    chk32("ld_half_s", rd, 32'hFFFFF176);
    do_req(1'b0, 2'd1, 1'b0, 32'd200, 32'd0, lat, rd);
    chk32("ld_half_u", rd, 32'h0000F176);
    do_req(1'b0, 2'd0, 1'b1, 32'd200, 32'd0, lat, rd);
    chk32("ld_byte_s", rd, 32'h00000076);
    do_req(1'b0, 2'd0, 1'b0, 32'd200, 32'd0, lat, rd);
    chk32("ld_byte_u", rd, 32'h00000076);

    r0 = n_rd; w0 = n_wr;
    do_req(1'b1, 2'd0, 1'b0, 32'd200, 32'h123456AB, lat, rd);
    chk32("st_byte_lat", 32'(lat), 32'd4);
    chk32("st_byte_nrd", 32'(n_rd - r0), 32'd1);
    chk32("st_byte_nwr", 32'(n_wr - w0), 32'd1);
    chk32("st_byte_din", last_wdat, 32'hF00FF1AB);
    do_req(1'b0, 2'd2, 1'b0, 32'd200, 32'd0, lat, rd);
    chk32("ld_after_byte", rd, 32'hF00FF1AB);

    do_req(1'b1, 2'd3, 1'b0, 32'd208, 32'hCAFEBABE, lat, rd);
    chk32("st_size3_lat", 32'(lat), 32'd2);
    do_req(1'b0, 2'd3, 1'b1, 32'd208, 32'd0, lat, rd);
    chk32("ld_size3", rd, 32'hCAFEBABE);

    // Reset during CAP of a half store must leave memory untouched and give no response.
    do_req(1'b1, 2'd2, 1'b0, 32'd204, 32'h12345678, lat, rd);
    w0 = n_wr; v0 = n_rv;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'd204; req_wdata = 32'h0000BEEF;
    @(negedge clk);
    chk1("rmw_idle_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk1("rmw_rd", ram_read, 1'b1);
    @(negedge clk);
    chk1("rmw_cap_ready", req_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("rmw_rst_ready", req_ready, 1'b1);
    chk1("rmw_rst_write", ram_write, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk32("rmw_no_write", 32'(n_wr - w0), 32'd0);
    chk32("rmw_no_resp", 32'(n_rv - v0), 32'd0);
    chk32("rmw_word204", {ram[207], ram[206], ram[205], ram[204]}, 32'h12345678);
    do_req(1'b0, 2'd2, 1'b0, 32'd204, 32'd0, lat, rd);
    chk32("rmw_ld_lat", 32'(lat), 32'd3);
    chk32("rmw_ld", rd, 32'h12345678);

    // Randomized traffic; req_valid is often held across a whole transaction while fields change.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      req_valid  = ($urandom_range(0, 9) < 7);
      req_write  = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = 32'($urandom_range(0, 1020));
      req_wdata  = $urandom;
      if (i == 200) begin
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== gmem[i]) bad++;
    chk32("mem_final", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
